shot_capture: RTL and testbench

//   Upstream feeder for the scoring stage. Debounces the raw fire pushbutton and

---
 rtl/shot_capture.sv | 171 +++++++++++++++++
 tb/tb_shot_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_capture.sv
// shot_capture: debounces the fire button, latches the tracker spot on the next
// valid frame (or reports a miss on timeout), pulses trigger for the scoring
// stage, enforces a cooldown and tracks shots per round.
module shot_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 650_000,
  parameter int unsigned COOLDOWN_CYCLES = 32_500_000,
  parameter int unsigned SPOT_TIMEOUT    = 2_200_000,
  parameter int unsigned SHOTS_PER_ROUND = 10,
  parameter logic [10:0] MISS_X          = 11'd0,
  parameter logic [9:0]  MISS_Y          = 10'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire_btn,
  input  logic        new_round,
  input  logic        spot_valid,
  input  logic [10:0] spot_x,
  input  logic [9:0]  spot_y,
  output logic [10:0] hit_x,
  output logic [9:0]  hit_y,
  output logic        trigger,
  output logic        miss,
  output logic        clear,
  output logic [3:0]  shots_left,
  output logic        round_over,
  output logic        busy
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CD_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(SPOT_TIMEOUT + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LAST    = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(SPOT_TIMEOUT - 1);
  localparam logic [3:0]      SHOTS_INIT = 4'(SHOTS_PER_ROUND);

  typedef enum logic [2:0] {
    READY    = 3'd0,
    ARMED    = 3'd1,
    FIRE     = 3'd2,
    COOLDOWN = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state;
  logic              btn_meta;
  logic              btn_sync;
  logic              btn_db;
  logic              btn_db_q;
  logic [DB_W-1:0]   db_cnt;
  logic [CD_W-1:0]   cd_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              press;

  // Two-flop synchroniser for the asynchronous pushbutton.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= fire_btn;
      btn_sync <= btn_meta;
    end
  end

  // Debounced level follows the synchronised button only after a full run of equal samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        btn_db <= btn_sync;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  // Shot sequencer; new_round overrides every state, including the FIRE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= READY;
      hit_x      <= '0;
      hit_y      <= '0;
      trigger    <= 1'b0;
      miss       <= 1'b0;
      clear      <= 1'b0;
      shots_left <= SHOTS_INIT;
      round_over <= 1'b0;
      busy       <= 1'b0;
      cd_cnt     <= '0;
      to_cnt     <= '0;
    end else begin
      trigger <= 1'b0;
      clear   <= 1'b0;
      if (new_round) begin
        state      <= READY;
        clear      <= 1'b1;
        shots_left <= SHOTS_INIT;
        miss       <= 1'b0;
        round_over <= 1'b0;
        busy       <= 1'b0;
        cd_cnt     <= '0;
        to_cnt     <= '0;
      end else begin
        case (state)
          READY: begin
            if (press && shots_left != 4'd0) begin
              state  <= ARMED;
              to_cnt <= '0;
              busy   <= 1'b1;
            end
          end
          ARMED: begin
            if (spot_valid) begin
              hit_x <= spot_x;
              hit_y <= spot_y;
              miss  <= 1'b0;
              state <= FIRE;
            end else if (to_cnt == TO_LAST) begin
              hit_x <= MISS_X;
              hit_y <= MISS_Y;
              miss  <= 1'b1;
              state <= FIRE;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          FIRE: begin
            trigger <= 1'b1;
            if (shots_left != 4'd0) begin
              shots_left <= shots_left - 4'd1;
            end
            cd_cnt <= '0;
            state  <= COOLDOWN;
          end
          COOLDOWN: begin
            if (cd_cnt == CD_LAST) begin
              if (shots_left == 4'd0) begin
                state      <= DONE;
                round_over <= 1'b1;
              end else begin
                state <= READY;
                busy  <= 1'b0;
              end
            end else begin
              cd_cnt <= cd_cnt + CD_W'(1);
            end
          end
          DONE: begin
            round_over <= 1'b1;
          end
          default: begin
            state <= READY;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shot_capture.sv
// Directed bench for shot_capture with short debounce/cooldown/timeout values.
module tb_shot_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        fire_btn;
  logic        new_round;
  logic        spot_valid;
  logic [10:0] spot_x;
  logic [9:0]  spot_y;
  logic [10:0] hit_x;
  logic [9:0]  hit_y;
  logic        trigger;
  logic        miss;
  logic        clear;
  logic [3:0]  shots_left;
  logic        round_over;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int trig_cnt = 0;

  shot_capture #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(8),
    .SPOT_TIMEOUT(20),
    .SHOTS_PER_ROUND(3),
    .MISS_X(11'd0),
    .MISS_Y(10'd0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fire_btn(fire_btn),
    .new_round(new_round),
    .spot_valid(spot_valid),
    .spot_x(spot_x),
    .spot_y(spot_y),
    .hit_x(hit_x),
    .hit_y(hit_y),
    .trigger(trigger),
    .miss(miss),
    .clear(clear),
    .shots_left(shots_left),
    .round_over(round_over),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Count every trigger pulse seen at a clock edge.
  always @(posedge clk) begin
    if (trigger) trig_cnt <= trig_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Clean press: hold 8 clk, release 8 clk; ARMED is reached 7 clk after the drive.
  task automatic press_btn();
    fire_btn = 1'b1;
    tick(8);
    fire_btn = 1'b0;
    tick(8);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hit_x"}, 32'(hit_x), 32'd0);
    check({tag, "_hit_y"}, 32'(hit_y), 32'd0);
    check({tag, "_trigger"}, 32'(trigger), 32'd0);
    check({tag, "_miss"}, 32'(miss), 32'd0);
    check({tag, "_clear"}, 32'(clear), 32'd0);
    check({tag, "_shots_left"}, 32'(shots_left), 32'd3);
    check({tag, "_round_over"}, 32'(round_over), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    fire_btn   = 1'b0;
    new_round  = 1'b0;
    spot_valid = 1'b0;
    spot_x     = '0;
    spot_y     = '0;
    tick(3);
    check_reset_values("rst");
    reset = 1'b0;
    tick(2);
    check("idle_busy", 32'(busy), 32'd0);

    // Bounce 1-0-1 then hold: one press, ARMED 11 clk after the first edge.
    fire_btn = 1'b1; tick(2);
    fire_btn = 1'b0; tick(2);
    fire_btn = 1'b1; tick(6);
    check("bounce_pre_busy", 32'(busy), 32'd0);
    tick(1);
    check("bounce_busy", 32'(busy), 32'd1);

    // Spot 5 clk after press: hit latched next clk, trigger one clk later.
    tick(4);
    spot_valid = 1'b1; spot_x = 11'd530; spot_y = 10'd400;
    tick(1);
    spot_valid = 1'b0; spot_x = '0; spot_y = '0;
    check("s1_hit_x_early", 32'(hit_x), 32'd530);
    check("s1_hit_y_early", 32'(hit_y), 32'd400);
    check("s1_trig_early", 32'(trigger), 32'd0);
    tick(1);
    check("s1_trigger", 32'(trigger), 32'd1);
    check("s1_miss", 32'(miss), 32'd0);
    check("s1_shots_left", 32'(shots_left), 32'd2);
    tick(1);
    check("s1_trig_pulse", 32'(trigger), 32'd0);
    fire_btn = 1'b0;
    tick(6);
    check("s1_cooldown_busy", 32'(busy), 32'd1);
    tick(1);
    check("s1_ready_busy", 32'(busy), 32'd0);
    check("s1_hit_x_held", 32'(hit_x), 32'd530);

    // Timeout shot: 20 clk in ARMED, then miss coords and trigger.
    press_btn();
    check("s2_armed", 32'(busy), 32'd1);
    tick(10);
    check("s2_no_trig_yet", 32'(trigger), 32'd0);
    check("s2_no_miss_yet", 32'(miss), 32'd0);
    tick(1);
    check("s2_hit_x", 32'(hit_x), 32'd0);
    check("s2_hit_y", 32'(hit_y), 32'd0);
    check("s2_miss", 32'(miss), 32'd1);
    tick(1);
    check("s2_trigger", 32'(trigger), 32'd1);
    check("s2_shots_left", 32'(shots_left), 32'd1);

    // Press landing inside cooldown is dropped.
    fire_btn = 1'b1;
    tick(8);
    check("cd_press_ignored", 32'(busy), 32'd0);
    fire_btn = 1'b0;
    tick(8);
    check("cd_press_still_idle", 32'(busy), 32'd0);
    check("trig_cnt_2", 32'(trig_cnt), 32'd2);

    // Third shot empties the round.
    press_btn();
    spot_valid = 1'b1; spot_x = 11'd1500; spot_y = 10'd2;
    tick(1);
    spot_valid = 1'b0;
    tick(1);
    check("s3_trigger", 32'(trigger), 32'd1);
    check("s3_hit_x", 32'(hit_x), 32'd1500);
    check("s3_hit_y", 32'(hit_y), 32'd2);
    check("s3_miss", 32'(miss), 32'd0);
    check("s3_shots_left", 32'(shots_left), 32'd0);
    tick(7);
    check("s3_not_over_yet", 32'(round_over), 32'd0);
    tick(1);
    check("s3_round_over", 32'(round_over), 32'd1);
    check("s3_done_busy", 32'(busy), 32'd1);

    // Fourth press in DONE does nothing.
    press_btn();
    tick(4);
    check("s4_no_trigger", 32'(trig_cnt), 32'd3);
    check("s4_round_over", 32'(round_over), 32'd1);
    check("s4_shots_left", 32'(shots_left), 32'd0);

    // new_round from DONE.
    new_round = 1'b1;
    tick(1);
    new_round = 1'b0;
    check("nr_clear", 32'(clear), 32'd1);
    check("nr_busy", 32'(busy), 32'd0);
    check("nr_round_over", 32'(round_over), 32'd0);
    check("nr_shots_left", 32'(shots_left), 32'd3);
    check("nr_hit_x_kept", 32'(hit_x), 32'd1500);
    tick(1);
    check("nr_clear_pulse", 32'(clear), 32'd0);

    // new_round while ARMED aborts the shot.
    press_btn();
    check("nra_armed", 32'(busy), 32'd1);
    new_round = 1'b1;
    tick(1);
    new_round = 1'b0;
    check("nra_clear", 32'(clear), 32'd1);
    check("nra_busy", 32'(busy), 32'd0);
    check("nra_shots_left", 32'(shots_left), 32'd3);
    tick(1);
    check("nra_clear_pulse", 32'(clear), 32'd0);
    tick(25);
    check("nra_no_trigger", 32'(trig_cnt), 32'd3);
    check("nra_idle", 32'(busy), 32'd0);

    // new_round in the FIRE cycle suppresses the trigger.
    press_btn();
    spot_valid = 1'b1; spot_x = 11'd700; spot_y = 10'd300;
    tick(1);
    spot_valid = 1'b0;
    new_round = 1'b1;
    tick(1);
    new_round = 1'b0;
    check("nrf_trigger", 32'(trigger), 32'd0);
    check("nrf_clear", 32'(clear), 32'd1);
    check("nrf_shots_left", 32'(shots_left), 32'd3);
    check("nrf_busy", 32'(busy), 32'd0);
    check("nrf_hit_x", 32'(hit_x), 32'd700);
    tick(2);
    check("nrf_trig_cnt", 32'(trig_cnt), 32'd3);

    // Reset asserted during cooldown.
    press_btn();
    spot_valid = 1'b1; spot_x = 11'd100; spot_y = 10'd50;
    tick(1);
    spot_valid = 1'b0;
    tick(1);
    check("rc_trigger", 32'(trigger), 32'd1);
    check("rc_shots_left", 32'(shots_left), 32'd2);
    tick(3);
    check("rc_cooldown_busy", 32'(busy), 32'd1);
    check("rc_trig_cnt", 32'(trig_cnt), 32'd4);
    reset = 1'b1;
    #1;
    check_reset_values("rc");
    tick(1);
    reset = 1'b0;
    tick(12);
    check("rc_after_busy", 32'(busy), 32'd0);
    check("rc_after_trig_cnt", 32'(trig_cnt), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
